// File: rtl/mmio_router.sv
// mmio_router: routes one core-side Membus master to NDEV device slaves.
// The router decodes each request against per-device base/size windows, with
// the lowest index winning on overlap, and keeps one request outstanding.
// Unmapped and timed-out accesses complete with an error response.
module mmio_router #(
    parameter int                      NDEV     = 4,
    parameter int                      ADDR_W   = 64,
    parameter int                      DATA_W   = 64,
    parameter logic [NDEV*ADDR_W-1:0]  DEV_BASE = '0,
    parameter logic [NDEV*ADDR_W-1:0]  DEV_SIZE = '0,
    parameter int                      TIMEOUT  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_wen,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_wmask,
    output logic                      req_rvalid,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    output logic [NDEV-1:0]           dev_valid,
    input  logic [NDEV-1:0]           dev_ready,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic                      dev_wen,
    output logic [DATA_W-1:0]         dev_wdata,
    output logic [DATA_W/8-1:0]       dev_wmask,
    input  logic [NDEV-1:0]           dev_rvalid,
    input  logic [NDEV*DATA_W-1:0]    dev_rdata
);

    localparam int SEL_W = (NDEV > 1) ? $clog2(NDEV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [31:0]           cnt, cnt_n;

    // Saved request: data fields carry no reset, only the control state does.
    logic [SEL_W-1:0]      sel_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wen_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wmask_q;

    logic                  dec_hit;
    logic [SEL_W-1:0]      dec_sel;
    logic [ADDR_W-1:0]     dec_off;
    logic                  can_accept;
    logic                  load;
    logic                  timeout_hit;

    // cnt counts cycles since acceptance, so the error response lands
    // TIMEOUT cycles after the request was taken.
    assign timeout_hit = (TIMEOUT != 0) && (cnt >= 32'(TIMEOUT - 1));

    // Window decode; scanning downward lets the lowest matching index win.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        dec_off = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if ((DEV_SIZE[i*ADDR_W +: ADDR_W] != '0) &&
                (req_addr >= DEV_BASE[i*ADDR_W +: ADDR_W]) &&
                ((req_addr - DEV_BASE[i*ADDR_W +: ADDR_W]) < DEV_SIZE[i*ADDR_W +: ADDR_W])) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
                dec_off = req_addr - DEV_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state, counter and all bus outputs; reset forces every output low.
    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        can_accept = 1'b0;
        load       = 1'b0;
        req_ready  = 1'b0;
        req_rvalid = 1'b0;
        req_rdata  = '0;
        req_err    = 1'b0;
        dev_valid  = '0;
        dev_addr   = '0;
        dev_wen    = 1'b0;
        dev_wdata  = '0;
        dev_wmask  = '0;

        unique case (state)
            IDLE: begin
                req_ready  = 1'b1;
                can_accept = 1'b1;
            end
            ISSUE: begin
                dev_valid[sel_q] = 1'b1;
                dev_addr         = addr_q;
                dev_wen          = wen_q;
                dev_wdata        = wdata_q;
                dev_wmask        = wmask_q;
                if (dev_ready[sel_q]) begin
                    state_n = WAIT;
                    cnt_n   = cnt + 32'd1;
                end else if (timeout_hit) begin
                    state_n = ERR;
                end else begin
                    cnt_n   = cnt + 32'd1;
                end
            end
            WAIT: begin
                if (dev_rvalid[sel_q]) begin
                    req_rvalid = 1'b1;
                    req_rdata  = dev_rdata[int'(sel_q)*DATA_W +: DATA_W];
                    req_ready  = 1'b1;
                    can_accept = 1'b1;
                    state_n    = IDLE;
                end else if (timeout_hit) begin
                    state_n = ERR;
                end else begin
                    cnt_n   = cnt + 32'd1;
                end
            end
            ERR: begin
                req_rvalid = 1'b1;
                req_err    = 1'b1;
                req_ready  = 1'b1;
                can_accept = 1'b1;
                state_n    = IDLE;
            end
        endcase

        // A new request is decoded and presented in the cycle it is accepted.
        if (can_accept && req_valid) begin
            load  = 1'b1;
            cnt_n = 32'd1;
            if (dec_hit) begin
                dev_valid[dec_sel] = 1'b1;
                dev_addr           = dec_off;
                dev_wen            = req_wen;
                dev_wdata          = req_wdata;
                dev_wmask          = req_wmask;
                state_n            = dev_ready[dec_sel] ? WAIT : ISSUE;
            end else begin
                state_n = ERR;
            end
        end

        if (rst) begin
            load       = 1'b0;
            req_ready  = 1'b0;
            req_rvalid = 1'b0;
            req_rdata  = '0;
            req_err    = 1'b0;
            dev_valid  = '0;
            dev_addr   = '0;
            dev_wen    = 1'b0;
            dev_wdata  = '0;
            dev_wmask  = '0;
        end
    end

    // Control state: FSM state and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Capture the accepted request for replay during ISSUE and for response routing.
    always_ff @(posedge clk) begin
        if (load) begin
            sel_q   <= dec_sel;
            addr_q  <= dec_off;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
        end
    end

endmodule
